// File: rtl/furv_dmem_if.sv
// Load/store port bundle between the furv core (master) and its data memory (slave).
// Port names match the core so the two connect name-for-name.
interface furv_dmem_if;
    logic        mem;
    logic        mem_write;
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        ack;
    logic        err;

    modport master (
        output mem, mem_write, addr, sel, data_out,
        input  data_in, ack, err
    );

    modport slave (
        input  mem, mem_write, addr, sel, data_out,
        output data_in, ack, err
    );
endinterface

// File: rtl/furv_dmem.sv
// Word-organised data memory for the furv load/store port, IDLE/WAIT/ACK responder.
// Optional macro FURV_DMEM_BOUNDS_EN: out-of-range requests are acked harmlessly and flag a sticky err.
module furv_dmem #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 0
) (
    input  logic       clk,
    input  logic       rst,
    furv_dmem_if.slave bus,
    output logic [1:0] dbg_state
);
    // Handshake: the initiator raises mem with stable request fields and holds them
    // until ack; ack is a single-cycle pulse and data_in is meaningful only while ack=1.
    // Dropping mem during WAIT aborts the transaction (no write, no ack).

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [3:0]    cnt, cnt_d;
    logic          hold;
    logic          take;
    logic          fire;

    logic [31:0]   mem_arr [DEPTH];

    logic [AW-1:0] a_idx;
    logic [3:0]    a_sel;
    logic          a_we;
    logic [31:0]   a_wdata;
    logic          a_oob;

    logic          req_oob;
    logic [AW-1:0] rd_idx;
    logic          rd_oob;

    logic          ack_q;
    logic [31:0]   data_in_q;

`ifdef FURV_DMEM_BOUNDS_EN
    assign req_oob = (bus.addr >> AW) != 30'd0;
`else
    // Without bounds checking the high address bits simply wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[29:AW];
    assign req_oob        = 1'b0;
`endif

    // In IDLE the array is addressed straight from the request; afterwards from the latch.
    assign rd_idx = (state == S_IDLE) ? bus.addr[AW-1:0] : a_idx;
    assign rd_oob = (state == S_IDLE) ? req_oob : a_oob;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        take    = 1'b0;
        fire    = 1'b0;
        case (state)
            S_IDLE: begin
                // hold blocks the cycle right after ACK so a held request is re-sampled fresh.
                if (bus.mem && !hold) begin
                    take  = 1'b1;
                    cnt_d = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d = S_ACK;
                        fire    = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.mem) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt == 4'd1) begin
                    state_d = S_ACK;
                    fire    = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            hold      <= 1'b0;
            ack_q     <= 1'b0;
            data_in_q <= 32'd0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            hold      <= (state == S_ACK);
            ack_q     <= fire;
            data_in_q <= (fire && !rd_oob) ? mem_arr[rd_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            a_idx   <= bus.addr[AW-1:0];
            a_sel   <= bus.sel;
            a_we    <= bus.mem_write;
            a_wdata <= bus.data_out;
            a_oob   <= req_oob;
        end
    end

    // Store commits on the edge that ends ACK; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (!rst && state == S_ACK && a_we && !a_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (a_sel[i]) begin
                    mem_arr[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef FURV_DMEM_BOUNDS_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == S_ACK && a_oob) begin
            err_q <= 1'b1;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.ack     = ack_q;
    assign bus.data_in = data_in_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_furv_dmem.sv
// Self-checking bench for furv_dmem: one LATENCY=0 and one LATENCY=3 instance share clk/rst.
// Load results go through an expected queue; a reference array models memory contents.
module tb_furv_dmem;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    furv_dmem_if if0 ();
    furv_dmem_if if3 ();
    logic [1:0] st0, st3;

    furv_dmem #(.DEPTH(1024), .LATENCY(0)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .dbg_state(st0)
    );
    furv_dmem #(.DEPTH(1024), .LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .bus(if3.slave), .dbg_state(st3)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl [2][1024];

`ifdef FURV_DMEM_BOUNDS_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    function automatic int slot(input int d);
        return (d == 3) ? 1 : 0;
    endfunction

    function automatic logic [31:0] mdl_read(input int d, input logic [29:0] a);
`ifdef FURV_DMEM_BOUNDS_EN
        if (a >= 30'd1024) return 32'd0;
`endif
        return mdl[slot(d)][a[9:0]];
    endfunction

    task automatic mdl_write(input int d, input logic [29:0] a, input logic [3:0] s, input logic [31:0] wd);
`ifdef FURV_DMEM_BOUNDS_EN
        if (a >= 30'd1024) return;
`endif
        for (int i = 0; i < 4; i++) begin
            if (s[i]) mdl[slot(d)][a[9:0]][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    function automatic logic get_ack(input int d);
        return (d == 3) ? if3.ack : if0.ack;
    endfunction

    function automatic logic [31:0] get_data(input int d);
        return (d == 3) ? if3.data_in : if0.data_in;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 3) ? if3.err : if0.err;
    endfunction

    function automatic logic [1:0] get_state(input int d);
        return (d == 3) ? st3 : st0;
    endfunction

    task automatic drive(input int d, input logic m, input logic we, input logic [29:0] a,
                         input logic [3:0] s, input logic [31:0] wd);
        if (d == 3) begin
            if3.mem = m; if3.mem_write = we; if3.addr = a; if3.sel = s; if3.data_out = wd;
        end else begin
            if0.mem = m; if0.mem_write = we; if0.addr = a; if0.sel = s; if0.data_out = wd;
        end
    endtask

    // One full transaction from a negedge; leaves the DUT idle and ready to sample.
    task automatic xact(input int d, input logic we, input logic [29:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input string tag);
        int          cyc = 0;
        bit          got = 0;
        int          lat = (d == 3) ? 3 : 0;
        logic [31:0] exp;
        if (!we) exp_q.push_back(mdl_read(d, a));
        drive(d, 1'b1, we, a, s, wd);
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            got = get_ack(d);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s ack_timeout got no ack after %0d cycles", tag, cyc);
            if (!we) void'(exp_q.pop_back());
        end else begin
            checks++;
            if (cyc != lat + 1) begin
                errors++;
                $display("FAIL %s latency got %0d want %0d", tag, cyc, lat + 1);
            end
            if (!we) begin
                exp = exp_q.pop_front();
                checks++;
                if (get_data(d) !== exp) begin
                    errors++;
                    $display("FAIL %s load_data got %h want %h", tag, get_data(d), exp);
                end
            end
        end
        drive(d, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        if (we) mdl_write(d, a, s, wd);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        drive(3, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int d = (k == 0) ? 0 : 3;
            checks++;
            if (get_ack(d) !== 1'b0) begin
                errors++; $display("FAIL reset_ack dut%0d got %b want 0", d, get_ack(d));
            end
            checks++;
            if (get_data(d) !== 32'd0) begin
                errors++; $display("FAIL reset_data dut%0d got %h want 0", d, get_data(d));
            end
            checks++;
            if (get_err(d) !== 1'b0) begin
                errors++; $display("FAIL reset_err dut%0d got %b want 0", d, get_err(d));
            end
            checks++;
            if (get_state(d) !== 2'd0) begin
                errors++; $display("FAIL reset_state dut%0d got %0d want 0", d, get_state(d));
            end
        end
    endtask

    task automatic test_basic();
        xact(0, 1'b1, 30'd5, 4'b1111, 32'hDEADBEEF, "l0_store5");
        xact(0, 1'b0, 30'd5, 4'b1111, 32'd0, "l0_load5");
        xact(0, 1'b1, 30'd5, 4'b0000, 32'h0BAD0BAD, "sel0_store");
        xact(0, 1'b0, 30'd5, 4'b0001, 32'd0, "load_sel_ignored");
    endtask

    task automatic test_lanes();
        xact(0, 1'b1, 30'd7, 4'b1111, 32'h11223344, "lane_preload");
        xact(0, 1'b1, 30'd7, 4'b0100, 32'hAAAAAAAA, "lane_byte2");
        xact(0, 1'b1, 30'd7, 4'b0011, 32'h55555555, "lane_half0");
        xact(0, 1'b0, 30'd7, 4'b1111, 32'd0, "lane_reload");
    endtask

    task automatic test_random();
        for (int i = 16; i < 24; i++) begin
            xact(3, 1'b1, 30'(i), 4'b1111, $urandom, "rand_preload");
        end
        for (int n = 0; n < 10; n++) begin
            logic [29:0] a = 30'($urandom_range(16, 23));
            if ($urandom_range(0, 1) == 1)
                xact(3, 1'b1, a, 4'($urandom_range(0, 15)), $urandom, "rand_store");
            else
                xact(3, 1'b0, a, 4'($urandom_range(0, 15)), 32'd0, "rand_load");
        end
    endtask

    task automatic test_back_to_back();
        int          cyc = 0;
        int          n = 0;
        int          t[3];
        logic        prev = 1'b0;
        logic [31:0] exp;
        xact(3, 1'b1, 30'd9, 4'b1111, $urandom, "b2b_preload");
        for (int i = 0; i < 3; i++) exp_q.push_back(mdl_read(3, 30'd9));
        drive(3, 1'b1, 1'b0, 30'd9, 4'b1111, 32'd0);
        while (n < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (get_ack(3)) begin
                checks++;
                if (prev) begin
                    errors++; $display("FAIL b2b_consecutive_ack at cycle %0d got 2 cycles want 1", cyc);
                end
                t[n] = cyc;
                exp = exp_q.pop_front();
                checks++;
                if (get_data(3) !== exp) begin
                    errors++; $display("FAIL b2b_data got %h want %h", get_data(3), exp);
                end
                n++;
            end
            prev = get_ack(3);
        end
        drive(3, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL b2b_ack_count got %0d want 3", n);
            exp_q.delete();
        end else begin
            checks++;
            if (t[0] != 4) begin
                errors++; $display("FAIL b2b_first_latency got %0d want 4", t[0]);
            end
            checks++;
            if (t[1] - t[0] != 6 || t[2] - t[1] != 6) begin
                errors++; $display("FAIL b2b_spacing got %0d,%0d want 6,6", t[1] - t[0], t[2] - t[1]);
            end
        end
        repeat (8) @(negedge clk);
        checks++;
        if (st3 !== 2'd0) begin
            errors++; $display("FAIL b2b_idle_after got %0d want 0", st3);
        end
    endtask

    task automatic test_abort();
        bit seen = 0;
        xact(3, 1'b1, 30'd2, 4'b1111, 32'h0, "abort_preload");
        drive(3, 1'b1, 1'b1, 30'd2, 4'b1111, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        checks++;
        if (st3 !== 2'd1) begin
            errors++; $display("FAIL abort_in_wait got state %0d want 1", st3);
        end
        drive(3, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        repeat (8) begin
            @(negedge clk);
            if (if3.ack) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL abort_no_ack got ack 1 want 0");
        end
        checks++;
        if (st3 !== 2'd0) begin
            errors++; $display("FAIL abort_idle got state %0d want 0", st3);
        end
        xact(3, 1'b0, 30'd2, 4'b1111, 32'd0, "abort_reload");
    endtask

    task automatic test_bounds();
        xact(0, 1'b1, 30'd0, 4'b1111, 32'hA5A5A5A5, "bounds_preload0");
        xact(0, 1'b1, 30'h400, 4'b1111, 32'h12345678, "bounds_store400");
        xact(0, 1'b0, 30'd0, 4'b1111, 32'd0, "bounds_load0");
        xact(0, 1'b0, 30'h400, 4'b1111, 32'd0, "bounds_load400");
        repeat (5) @(negedge clk);
        checks++;
        if (if0.err !== EXP_ERR) begin
            errors++; $display("FAIL bounds_err got %b want %b", if0.err, EXP_ERR);
        end
        checks++;
        if (if3.err !== 1'b0) begin
            errors++; $display("FAIL bounds_err_other got %b want 0", if3.err);
        end
    endtask

    task automatic test_reset_in_ack();
        int cyc = 0;
        bit got = 0;
        xact(3, 1'b1, 30'd3, 4'b1111, 32'h0, "rstack_preload");
        drive(3, 1'b1, 1'b1, 30'd3, 4'b1111, 32'hCAFEF00D);
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            got = if3.ack;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL rstack_timeout got no ack after %0d cycles", cyc);
        end
        rst = 1'b1;
        drive(3, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        @(negedge clk);
        checks++;
        if (if3.ack !== 1'b0) begin
            errors++; $display("FAIL rstack_ack_drop got %b want 0", if3.ack);
        end
        checks++;
        if (if0.err !== 1'b0) begin
            errors++; $display("FAIL rstack_err_clear got %b want 0", if0.err);
        end
        rst = 1'b0;
        @(negedge clk);
        xact(3, 1'b0, 30'd3, 4'b1111, 32'd0, "rstack_reload");
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_lanes();
        test_random();
        test_back_to_back();
        test_abort();
        test_bounds();
        test_reset_in_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
